// File: rtl/prog_delay_line_pkg.sv
// Shared definitions for the programmable delay line: tap limits, step
// direction encodings and the per-channel tap update operation.
package prog_delay_line_pkg;

  localparam logic PDL_DIR_UP = 1'b1;
  localparam logic PDL_DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    TAP_HOLD = 2'd0,
    TAP_INC  = 2'd1,
    TAP_DEC  = 2'd2,
    TAP_LOAD = 2'd3
  } tap_op_e;

  function automatic int pdlTapMax(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/prog_delay_chan.sv
// One delay channel: shift line, registered tap mux, tap register with
// MOVE edge detection and a one-cycle flag for steps rejected at a limit.
module prog_delay_chan
  import prog_delay_line_pkg::*;
#(
  parameter int DATA_W      = 1,
  parameter int TAP_W       = 4,
  parameter int DEFAULT_TAP = 0
) (
  input  logic              i_clk,
  input  logic              i_rstN,
  input  logic              i_ce,
  input  logic [DATA_W-1:0] i_a,
  input  logic              i_load,
  input  logic [TAP_W-1:0]  i_delIn,
  input  logic              i_move,
  input  logic              i_direction,
  output logic [DATA_W-1:0] o_z,
  output logic [TAP_W-1:0]  o_tap,
  output logic              o_cflag
);

  localparam int               DEPTH   = pdlTapMax(TAP_W);
  localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(DEPTH);
  localparam logic [TAP_W-1:0] TAP_RST = TAP_W'(DEFAULT_TAP);

  logic [DATA_W-1:0] r_stage [DEPTH];
  logic [DATA_W-1:0] r_z;
  logic [TAP_W-1:0]  r_tap;
  logic              r_moveQ;
  logic              r_cflag;

  logic [TAP_W-1:0]  w_tapM1;
  logic [DATA_W-1:0] w_lineOut;
  logic              w_step;
  logic              w_reject;
  tap_op_e           w_op;

  assign w_tapM1   = r_tap - TAP_W'(1);
  assign w_lineOut = (r_tap == '0) ? i_a : r_stage[w_tapM1];
  assign w_step    = i_move & ~r_moveQ;

  // LOAD wins over a coincident step, and that step is dropped silently.
  always_comb begin
    w_op     = TAP_HOLD;
    w_reject = 1'b0;
    if (i_load) begin
      w_op = TAP_LOAD;
    end else if (w_step) begin
      if (i_direction == PDL_DIR_UP) begin
        if (r_tap != TAP_MAX) w_op = TAP_INC;
        else                  w_reject = 1'b1;
      end else begin
        if (r_tap != '0) w_op = TAP_DEC;
        else             w_reject = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
      r_z <= '0;
    end else if (i_ce) begin
      r_stage[0] <= i_a;
      for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
      r_z <= w_lineOut;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_tap   <= TAP_RST;
      r_moveQ <= 1'b0;
      r_cflag <= 1'b0;
    end else begin
      r_moveQ <= i_move;
      r_cflag <= w_reject;
      case (w_op)
        TAP_LOAD: r_tap <= i_delIn;
        TAP_INC:  r_tap <= r_tap + TAP_W'(1);
        TAP_DEC:  r_tap <= r_tap - TAP_W'(1);
        default:  r_tap <= r_tap;
      endcase
    end
  end

  assign o_z     = r_z;
  assign o_tap   = r_tap;
  assign o_cflag = r_cflag;

endmodule

// File: rtl/prog_delay_line.sv
// Multi-channel programmable delay line: one prog_delay_chan per channel,
// with the flat data/tap buses sliced per channel.
module prog_delay_line
  import prog_delay_line_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int DATA_W      = 1,
  parameter int TAP_W       = 4,
  parameter int DEFAULT_TAP = 0
) (
  input  logic                         CLK,
  input  logic                         RSTN,
  input  logic                         CE,
  input  logic [CHANNELS*DATA_W-1:0]   A,
  input  logic [CHANNELS-1:0]          LOAD,
  input  logic [TAP_W-1:0]             DEL_IN,
  input  logic [CHANNELS-1:0]          MOVE,
  input  logic                         DIRECTION,
  output logic [CHANNELS*DATA_W-1:0]   Z,
  output logic [CHANNELS*TAP_W-1:0]    TAP,
  output logic [CHANNELS-1:0]          CFLAG
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    prog_delay_chan #(
      .DATA_W      (DATA_W),
      .TAP_W       (TAP_W),
      .DEFAULT_TAP (DEFAULT_TAP)
    ) u_chan (
      .i_clk       (CLK),
      .i_rstN      (RSTN),
      .i_ce        (CE),
      .i_a         (A[c*DATA_W +: DATA_W]),
      .i_load      (LOAD[c]),
      .i_delIn     (DEL_IN),
      .i_move      (MOVE[c]),
      .i_direction (DIRECTION),
      .o_z         (Z[c*DATA_W +: DATA_W]),
      .o_tap       (TAP[c*TAP_W +: TAP_W]),
      .o_cflag     (CFLAG[c])
    );
  end

endmodule

// File: tb/tb_prog_delay_line.sv
// Scoreboard bench for prog_delay_line: a history-based channel model predicts
// Z/TAP/CFLAG each cycle, plus directed latency, limit, CE and reset checks.
module tb_prog_delay_line;

  localparam int CH      = 4;
  localparam int TW      = 4;
  localparam int DEF_TAP = 0;
  localparam int TAPMAX  = 15;

  logic        clk = 1'b0;
  logic        rstN;
  logic        ce;
  logic [3:0]  a;
  logic [3:0]  load;
  logic [3:0]  delIn;
  logic [3:0]  move;
  logic        dir;
  logic [3:0]  z;
  logic [15:0] tap;
  logic [3:0]  cflag;

  always #5 clk = ~clk;

  prog_delay_line #(
    .CHANNELS    (CH),
    .DATA_W      (1),
    .TAP_W       (TW),
    .DEFAULT_TAP (DEF_TAP)
  ) dut (
    .CLK       (clk),
    .RSTN      (rstN),
    .CE        (ce),
    .A         (a),
    .LOAD      (load),
    .DEL_IN    (delIn),
    .MOVE      (move),
    .DIRECTION (dir),
    .Z         (z),
    .TAP       (tap),
    .CFLAG     (cflag)
  );

  typedef struct packed {
    logic [3:0]  z;
    logic [15:0] tap;
    logic [3:0]  cflag;
  } exp_t;

  exp_t       expQ[$];
  int         testsRun = 0;
  int         testsFailed = 0;
  int         mTap[CH];
  logic       mMoveQ[CH];
  logic       mHist[CH][TAPMAX];
  logic [3:0] mZ;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < CH; c++) begin
      mTap[c]   = DEF_TAP;
      mMoveQ[c] = 1'b0;
      for (int k = 0; k < TAPMAX; k++) mHist[c][k] = 1'b0;
    end
    mZ = '0;
    expQ.delete();
  endtask

  // mHist[c][k] is the A sample taken k+1 CE cycles ago.
  task automatic applyStimulus();
    exp_t       e;
    logic [3:0] cf;
    cf = '0;
    for (int c = 0; c < CH; c++) begin
      if (ce) begin
        mZ[c] = (mTap[c] == 0) ? a[c] : mHist[c][mTap[c]-1];
        for (int k = TAPMAX-1; k > 0; k--) mHist[c][k] = mHist[c][k-1];
        mHist[c][0] = a[c];
      end
      if (load[c]) begin
        mTap[c] = int'(delIn);
      end else if (move[c] && !mMoveQ[c]) begin
        if (dir) begin
          if (mTap[c] < TAPMAX) mTap[c]++;
          else                  cf[c] = 1'b1;
        end else begin
          if (mTap[c] > 0) mTap[c]--;
          else             cf[c] = 1'b1;
        end
      end
      mMoveQ[c] = move[c];
    end
    e.z     = mZ;
    e.cflag = cf;
    for (int c = 0; c < CH; c++) e.tap[c*4 +: 4] = 4'(mTap[c]);
    expQ.push_back(e);
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      checkOutput("scoreboard empty", 32'd1, 32'd0);
    end else begin
      e = expQ.pop_front();
      checkOutput("sb Z", 32'(z), 32'(e.z));
      checkOutput("sb TAP", 32'(tap), 32'(e.tap));
      checkOutput("sb CFLAG", 32'(cflag), 32'(e.cflag));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int         lat;
    logic [3:0] zHold;

    rstN = 1'b0; ce = 1'b0; a = '0; load = '0; delIn = '0; move = '0; dir = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset Z", 32'(z), 32'd0);
    checkOutput("reset TAP", 32'(tap), 32'd0);
    checkOutput("reset CFLAG", 32'(cflag), 32'd0);
    rstN = 1'b1;
    ce   = 1'b1;

    // Tap 0: a one-cycle pulse shows up after exactly one edge.
    a[0] = 1'b1;
    lat  = 0;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus();
      a[0] = 1'b0;
      if (z[0] === 1'b1 && lat == 0) lat = k;
    end
    checkOutput("t1 latency tap0", 32'(lat), 32'd1);
    checkOutput("t1 TAP", 32'(tap), 32'd0);

    load = 4'b0001; delIn = 4'd5;
    applyStimulus();
    load = '0;
    checkOutput("t2 TAP0", 32'(tap[3:0]), 32'd5);
    a[0] = 1'b1;
    lat  = 0;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus();
      a[0] = 1'b0;
      if (z[0] === 1'b1 && lat == 0) lat = k;
    end
    checkOutput("t2 latency tap5", 32'(lat), 32'd6);

    load = 4'b0010; delIn = 4'd15;
    applyStimulus();
    load = '0; move = 4'b0010; dir = 1'b1;
    applyStimulus();
    checkOutput("t3 up limit TAP1", 32'(tap[7:4]), 32'd15);
    checkOutput("t3 up limit CFLAG1", 32'(cflag[1]), 32'd1);
    applyStimulus();
    checkOutput("t3 CFLAG1 one cycle", 32'(cflag[1]), 32'd0);
    move = '0;
    load = 4'b0010; delIn = 4'd0;
    applyStimulus();
    load = '0; move = 4'b0010; dir = 1'b0;
    applyStimulus();
    checkOutput("t3 dn limit TAP1", 32'(tap[7:4]), 32'd0);
    checkOutput("t3 dn limit CFLAG1", 32'(cflag[1]), 32'd1);
    move = '0;
    applyStimulus();
    checkOutput("t3 dn CFLAG1 one cycle", 32'(cflag[1]), 32'd0);

    load = 4'b0100; delIn = 4'd3;
    applyStimulus();
    load = '0; move = 4'b0100; dir = 1'b1;
    repeat (10) applyStimulus();
    checkOutput("t4 held MOVE TAP2", 32'(tap[11:8]), 32'd4);
    move = '0;
    applyStimulus();
    load = 4'b0100; delIn = 4'd9; move = 4'b0100;
    applyStimulus();
    checkOutput("t4 load+move TAP2", 32'(tap[11:8]), 32'd9);
    checkOutput("t4 load+move CFLAG2", 32'(cflag[2]), 32'd0);
    load = '0; move = '0;
    applyStimulus();
    checkOutput("t4 load+move CFLAG2 next", 32'(cflag[2]), 32'd0);

    // CE freeze with A toggling, then resume from held line contents.
    load = 4'b1000; delIn = 4'd2;
    applyStimulus();
    load = '0;
    for (int k = 0; k < 8; k++) begin
      a = 4'($urandom_range(0, 15));
      applyStimulus();
    end
    zHold = z;
    ce = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a = ~a;
      applyStimulus();
      checkOutput("t5 CE0 Z frozen", 32'(z), 32'(zHold));
    end
    ce = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a = 4'($urandom_range(0, 15));
      applyStimulus();
    end

    // Mixed random traffic with steps, loads and occasional CE drops.
    for (int k = 0; k < 80; k++) begin
      a     = 4'($urandom_range(0, 15));
      ce    = ($urandom_range(0, 7) != 0);
      move  = 4'($urandom_range(0, 15));
      dir   = 1'($urandom_range(0, 1));
      delIn = 4'($urandom_range(0, 15));
      load  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      applyStimulus();
    end

    ce = 1'b1; move = '0; load = 4'b1111; delIn = 4'd7;
    applyStimulus();
    load = '0;
    checkOutput("t6 taps 7", 32'(tap), 32'h7777);
    for (int k = 0; k < 12; k++) begin
      a = 4'($urandom_range(0, 15));
      applyStimulus();
    end
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("t6 async Z", 32'(z), 32'd0);
    checkOutput("t6 async CFLAG", 32'(cflag), 32'd0);
    checkOutput("t6 async TAP", 32'(tap), 32'd0);
    a = '0;
    modelReset();
    @(posedge clk);
    #1;
    rstN = 1'b1;
    a[0] = 1'b1;
    applyStimulus();
    a[0] = 1'b0;
    checkOutput("t6 post-reset latency", 32'(z[0]), 32'd1);
    for (int k = 0; k < 4; k++) applyStimulus();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
